packet_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter for one router output port (switch allocation stage of the VC router).
- Arbitrates among NUM_ARBITER_PORTS input requesters. Holds the grant for the whole packet, head to tail. Rotates priority after each tail flit transfers.
- Built on two fixed-priority arbiters (masked and unmasked request vectors) plus a registered grant and lock state machine.

---
 rtl/packet_rr_arbiter_pkg.sv | 40 ++++
 rtl/packet_rr_arbiter_fpa.sv | 21 ++
 rtl/packet_rr_arbiter.sv | 116 +++++++++++
 tb/tb_packet_rr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/packet_rr_arbiter_pkg.sv
// Shared router definitions for the switch-allocation arbiter: port count,
// index-width helpers and the lock state encoding.
package packet_rr_arbiter_pkg;

    localparam int ROUTER_PORTS      = 5;
    localparam int MAX_ARBITER_PORTS = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A single requester still needs a one-bit index so grant_id has a width.
    function automatic int id_width(input int num_ports);
        return (num_ports <= 1) ? 1 : clog2(num_ports);
    endfunction

    function automatic int onehot_to_bin(input logic [MAX_ARBITER_PORTS-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_ARBITER_PORTS; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/packet_rr_arbiter_fpa.sv
// Fixed-priority arbiter: the lowest-indexed active request wins.
module packet_rr_arbiter_fpa #(
    parameter int NUM_PORTS = 5
) (
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_gnt
);

    always_comb begin
        logic found;
        found = 1'b0;
        o_gnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_req[i] && !found) begin
                o_gnt[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-granular round-robin arbiter for one router output port: a grant is
// held from head to tail flit, and priority rotates after each tail transfer.
module packet_rr_arbiter
    import packet_rr_arbiter_pkg::*;
#(
    parameter  int NUM_ARBITER_PORTS = ROUTER_PORTS,
    localparam int ID_WIDTH          = id_width(NUM_ARBITER_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ARBITER_PORTS-1:0] req,
    input  logic [NUM_ARBITER_PORTS-1:0] req_tail,
    input  logic                         out_avail,
    output logic [NUM_ARBITER_PORTS-1:0] grant,
    output logic [ID_WIDTH-1:0]          grant_id,
    output logic                         grant_valid,
    output logic                         xfer
);

    arb_state_t                   r_state;
    arb_state_t                   w_state_next;
    logic [NUM_ARBITER_PORTS-1:0] r_grant;
    logic [NUM_ARBITER_PORTS-1:0] w_grant_next;
    logic [MAX_ARBITER_PORTS-1:0] w_grant_next_wide;
    logic [ID_WIDTH-1:0]          r_grant_id;
    logic [ID_WIDTH-1:0]          r_ptr;
    logic [ID_WIDTH-1:0]          w_ptr_next;
    logic [ID_WIDTH-1:0]          w_ptr_inc;
    logic [ID_WIDTH-1:0]          w_arb_ptr;
    logic [NUM_ARBITER_PORTS-1:0] w_mask;
    logic [NUM_ARBITER_PORTS-1:0] w_req_masked;
    logic [NUM_ARBITER_PORTS-1:0] w_gnt_masked;
    logic [NUM_ARBITER_PORTS-1:0] w_gnt_unmasked;
    logic [NUM_ARBITER_PORTS-1:0] w_rr_grant;
    logic                         w_xfer;
    logic                         w_tail_xfer;

    packet_rr_arbiter_fpa #(
        .NUM_PORTS (NUM_ARBITER_PORTS)
    ) u_fpa_masked (
        .i_req (w_req_masked),
        .o_gnt (w_gnt_masked)
    );

    packet_rr_arbiter_fpa #(
        .NUM_PORTS (NUM_ARBITER_PORTS)
    ) u_fpa_unmasked (
        .i_req (req),
        .o_gnt (w_gnt_unmasked)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_grant_id <= ID_WIDTH'(onehot_to_bin(w_grant_next_wide));
            r_ptr      <= w_ptr_next;
        end
    end

    // A tail transfer re-arbitrates with the already-advanced pointer so the
    // next packet is granted without a bubble cycle.
    always_comb begin
        w_ptr_inc = (r_grant_id == ID_WIDTH'(NUM_ARBITER_PORTS - 1)) ? '0
                                                                      : r_grant_id + ID_WIDTH'(1);
        w_arb_ptr = w_tail_xfer ? w_ptr_inc : r_ptr;
        for (int i = 0; i < NUM_ARBITER_PORTS; i++) begin
            w_mask[i] = (i >= int'(w_arb_ptr));
        end
        w_req_masked = req & w_mask;
        w_rr_grant   = (|w_req_masked) ? w_gnt_masked : w_gnt_unmasked;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant_next = w_rr_grant;
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_tail_xfer) begin
                    w_ptr_next   = w_ptr_inc;
                    w_grant_next = w_rr_grant;
                    w_state_next = (|w_rr_grant) ? ST_LOCKED : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
        w_grant_next_wide                        = '0;
        w_grant_next_wide[NUM_ARBITER_PORTS-1:0] = w_grant_next;
    end

    // The grant is one-hot, so masking with it selects the owner's req/tail.
    always_comb begin
        w_xfer      = (|r_grant) & out_avail & (|(r_grant & req));
        w_tail_xfer = w_xfer & (|(r_grant & req_tail));
        grant       = r_grant;
        grant_id    = r_grant_id;
        grant_valid = |r_grant;
        xfer        = w_xfer;
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Self-checking bench: a packet-level round-robin model predicts each cycle's
// outputs into a scoreboard that an independent monitor drains and compares.
module tb_packet_rr_arbiter;

    localparam int N   = 5;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   reqTail;
    logic           outAvail;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grantId;
    logic           grantValid;
    logic           xfer;

    typedef struct {
        logic [N-1:0] grant;
        int           grantId;
        logic         xfer;
    } expect_t;

    expect_t      sbQueue[$];
    int           checks = 0;
    int           errors = 0;
    int           modelOwner = -1;
    int           modelPtr = 0;
    bit           modelValid = 1'b0;
    logic         prevRst;
    logic [N-1:0] prevReq;
    logic [N-1:0] prevTail;
    logic         prevAvail;

    always #5 clk = ~clk;

    packet_rr_arbiter #(
        .NUM_ARBITER_PORTS (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_tail    (reqTail),
        .out_avail   (outAvail),
        .grant       (grant),
        .grant_id    (grantId),
        .grant_valid (grantValid),
        .xfer        (xfer)
    );

    // Circular search starting at the pointer: the first requester found wins.
    function automatic int rrPick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic advanceModel();
        if (prevRst) begin
            modelOwner = -1;
            modelPtr   = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (modelOwner < 0) begin
                if (prevReq != '0) modelOwner = rrPick(prevReq, modelPtr);
            end else if (prevAvail && prevReq[modelOwner] && prevTail[modelOwner]) begin
                modelPtr   = (modelOwner + 1) % N;
                modelOwner = rrPick(prevReq, modelPtr);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                                 input logic [N-1:0] tl, input logic av);
        expect_t e;
        @(posedge clk);
        #1;
        advanceModel();
        rst       = r;
        req       = rq;
        reqTail   = tl;
        outAvail  = av;
        prevRst   = r;
        prevReq   = rq;
        prevTail  = tl;
        prevAvail = av;
        if (modelValid) begin
            e.grant   = (modelOwner < 0) ? '0 : (N'(1) << modelOwner);
            e.grantId = (modelOwner < 0) ? 0 : modelOwner;
            e.xfer    = (modelOwner >= 0) && av && rq[modelOwner];
            sbQueue.push_back(e);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (grant !== e.grant) begin
            errors++;
            $display("[TB] FAIL grant at %0t: got %b expected %b", $time, grant, e.grant);
        end
        checks++;
        if (grantId !== IDW'(e.grantId)) begin
            errors++;
            $display("[TB] FAIL grant_id at %0t: got %0d expected %0d", $time, grantId, e.grantId);
        end
        checks++;
        if (grantValid !== (e.grant != '0)) begin
            errors++;
            $display("[TB] FAIL grant_valid at %0t: got %b expected %b", $time, grantValid, e.grant != '0);
        end
        checks++;
        if (xfer !== e.xfer) begin
            errors++;
            $display("[TB] FAIL xfer at %0t: got %b expected %b", $time, xfer, e.xfer);
        end
        checks++;
        if ($countones(grant) > 1) begin
            errors++;
            $display("[TB] FAIL onehot at %0t: got %b expected at most one bit", $time, grant);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
        end
    end

    task automatic resetDut();
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
    endtask

    initial begin
        int waitCycles;
        rst       = 1'b1;
        req       = '0;
        reqTail   = '0;
        outAvail  = 1'b0;
        prevRst   = 1'b1;
        prevReq   = '0;
        prevTail  = '0;
        prevAvail = 1'b0;

        // Reset with all requesters active, then release.
        applyStimulus(1'b1, 5'b11111, 5'b00000, 1'b0);
        applyStimulus(1'b1, 5'b11111, 5'b00000, 1'b0);
        repeat (3) applyStimulus(1'b0, 5'b11111, 5'b00000, 1'b0);

        // Back-to-back single-flit packets.
        resetDut();
        repeat (6) applyStimulus(1'b0, 5'b10101, 5'b11111, 1'b1);

        // Three-flit packet on port 1 while port 3 waits.
        resetDut();
        applyStimulus(1'b0, 5'b01010, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b01010, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b01010, 5'b01000, 1'b1);
        applyStimulus(1'b0, 5'b01010, 5'b01010, 1'b1);
        applyStimulus(1'b0, 5'b01000, 5'b01000, 1'b1);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);

        // Output stalls during a locked packet on port 2.
        resetDut();
        applyStimulus(1'b0, 5'b00100, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b00100, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b00100, 5'b00000, 1'b0);
        applyStimulus(1'b0, 5'b00100, 5'b00100, 1'b0);
        applyStimulus(1'b0, 5'b00100, 5'b00100, 1'b1);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);

        // Pointer wrap after a tail on the highest port.
        resetDut();
        applyStimulus(1'b0, 5'b10000, 5'b10000, 1'b1);
        repeat (4) applyStimulus(1'b0, 5'b10001, 5'b10001, 1'b1);

        // Reset while port 3 is mid-packet.
        resetDut();
        applyStimulus(1'b0, 5'b01000, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b01000, 5'b00000, 1'b1);
        applyStimulus(1'b1, 5'b01000, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b01001, 5'b00000, 1'b1);
        applyStimulus(1'b0, 5'b01001, 5'b00000, 1'b1);

        // Randomised traffic with occasional resets and stalls.
        resetDut();
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, N'($urandom), N'($urandom),
                          $urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);

        waitCycles = 0;
        while (sbQueue.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        @(negedge clk);
        if (sbQueue.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQueue.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
